// File: rtl/core_arf_sb_if.sv
// Operand/writeback/reservation bundle for core_arf_sb.
// master drives requests; slave (the register file) returns data/status.
interface core_arf_sb_if #(
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int R_PORTS   = 3,
  parameter int W_PORTS   = 2,
  parameter int RSV_PORTS = 1
);
  localparam int AW = $clog2(DEPTH);

  logic                     flush_i;
  logic [R_PORTS*AW-1:0]    rd_addr_i;
  logic [R_PORTS*DW-1:0]    rd_data_o;
  logic [R_PORTS-1:0]       rd_busy_o;
  logic [W_PORTS-1:0]       wr_en_i;
  logic [W_PORTS*AW-1:0]    wr_addr_i;
  logic [W_PORTS*DW-1:0]    wr_data_i;
  logic [W_PORTS-1:0]       wr_rel_i;
  logic [RSV_PORTS-1:0]     rsv_en_i;
  logic [RSV_PORTS*AW-1:0]  rsv_addr_i;
  logic [RSV_PORTS-1:0]     rsv_ready_o;
  logic                     err_o;

  modport master (
    output flush_i, rd_addr_i,
    output wr_en_i, wr_addr_i,
    output wr_data_i, wr_rel_i,
    output rsv_en_i, rsv_addr_i,
    input  rd_data_o, rd_busy_o,
    input  rsv_ready_o, err_o
  );

  modport slave (
    input  flush_i, rd_addr_i,
    input  wr_en_i, wr_addr_i,
    input  wr_data_i, wr_rel_i,
    input  rsv_en_i, rsv_addr_i,
    output rd_data_o, rd_busy_o,
    output rsv_ready_o, err_o
  );
endinterface

// File: rtl/core_arf_sb.sv
// Multi-port architectural register file with pending-write scoreboard.
// Ports: clk_i, arst_ni (async, active-low), bus (core_arf_sb_if.slave).
module core_arf_sb #(
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int R_PORTS   = 3,
  parameter int W_PORTS   = 2,
  parameter int RSV_PORTS = 1,
  parameter int PW        = 2
) (
  input logic          clk_i,
  input logic          arst_ni,
  core_arf_sb_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int MAX = (1 << PW) - 1;
  // Headroom for a full burst of reservations in one cycle.
  localparam int LIM = MAX - RSV_PORTS;

  logic [DW-1:0] r_mem  [DEPTH];
  logic [PW-1:0] r_pend [DEPTH];
  logic          r_err;

  logic [AW-1:0] w_ra   [R_PORTS];
  logic [DW-1:0] w_rd   [R_PORTS];
  logic [AW-1:0] w_sa   [RSV_PORTS];
  logic          w_acc  [RSV_PORTS];
  logic [PW-1:0] w_pnx  [DEPTH];
  int            w_inc  [DEPTH];
  int            w_dec  [DEPTH];
  int            w_sum  [DEPTH];
  logic          w_uf;

  assign bus.err_o = r_err;

  // Read with write bypass; later ports override earlier ones.
  always_comb begin
    bus.rd_data_o = '0;
    bus.rd_busy_o = '0;
    for (int k = 0; k < R_PORTS; k++) begin
      w_ra[k] = bus.rd_addr_i[k*AW +: AW];
      w_rd[k] = r_mem[w_ra[k]];
      for (int w = 0; w < W_PORTS; w++) begin
        if (bus.wr_en_i[w] &&
            bus.wr_addr_i[w*AW +: AW] == w_ra[k])
          w_rd[k] = bus.wr_data_i[w*DW +: DW];
      end
      if (w_ra[k] == '0) w_rd[k] = '0;
      bus.rd_data_o[k*DW +: DW] = w_rd[k];
      bus.rd_busy_o[k] = (w_ra[k] != '0) &&
                         (r_pend[w_ra[k]] != '0);
    end
  end

  always_comb begin
    bus.rsv_ready_o = '0;
    for (int k = 0; k < RSV_PORTS; k++) begin
      w_sa[k] = bus.rsv_addr_i[k*AW +: AW];
      bus.rsv_ready_o[k] = (w_sa[k] != '0) &&
                           (int'(r_pend[w_sa[k]]) <= LIM);
      w_acc[k] = bus.rsv_en_i[k] && bus.rsv_ready_o[k];
    end
  end

  // Net counter change; underflow clamps to zero and flags error.
  always_comb begin
    w_uf = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      w_inc[r] = 0;
      w_dec[r] = 0;
      for (int k = 0; k < RSV_PORTS; k++) begin
        if (w_acc[k] && w_sa[k] == AW'(r))
          w_inc[r] = w_inc[r] + 1;
      end
      for (int w = 0; w < W_PORTS; w++) begin
        if (r != 0 && bus.wr_rel_i[w] &&
            bus.wr_addr_i[w*AW +: AW] == AW'(r))
          w_dec[r] = w_dec[r] + 1;
      end
      w_sum[r] = int'(r_pend[r]) + w_inc[r];
      if (w_sum[r] >= w_dec[r]) begin
        w_pnx[r] = PW'(w_sum[r] - w_dec[r]);
      end else begin
        w_pnx[r] = '0;
        w_uf     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int r = 0; r < DEPTH; r++) begin
        r_mem[r]  <= '0;
        r_pend[r] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      // Last assignment wins, so the highest port takes a collision.
      for (int w = 0; w < W_PORTS; w++) begin
        if (bus.wr_en_i[w] &&
            bus.wr_addr_i[w*AW +: AW] != '0)
          r_mem[bus.wr_addr_i[w*AW +: AW]] <=
            bus.wr_data_i[w*DW +: DW];
      end
      for (int r = 0; r < DEPTH; r++) begin
        r_pend[r] <= bus.flush_i ? '0 : w_pnx[r];
      end
      if (w_uf && !bus.flush_i) r_err <= 1'b1;
    end
  end
endmodule
